// File: rtl/pmem_loader_pkg.sv
// Shared types and constants for the program-memory boot loader.
package loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_MAGIC,
      LEN_HI,
      LEN_LO,
      WORD,
      CHECK,
      FINISH
   } loader_state_t;

   localparam logic [7:0] LOADER_MAGIC = 8'hA5;
   localparam int         WORD_W       = 18;

   // Only the low two bits of the leading byte carry data.
   function automatic logic [WORD_W-1:0] mk_word(input logic [1:0] b2,
                                                 input logic [7:0] b1,
                                                 input logic [7:0] b0);
      return {b2, b1, b0};
   endfunction

endpackage

// File: rtl/pmem_loader_timeout.sv
// Inter-byte timeout: clearable down-counter that pulses expire_o after
// TIMEOUT_CYCLES consecutive running cycles without a clear.
module loader_timeout #(
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic clk,
   input  logic rst,
   input  logic run_i,
   input  logic clr_i,
   output logic expire_o
);

   localparam int            CW   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYCLES);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt_q <= LOAD;
      else if (clr_i || !run_i)
         cnt_q <= LOAD;
      else if (cnt_q != '0)
         cnt_q <= cnt_q - 1'b1;
   end

   // A byte arriving on the expiry cycle clears instead of expiring.
   assign expire_o = run_i && !clr_i && (cnt_q == CW'(1));

endmodule

// File: rtl/pmem_loader.sv
// Boot loader: parses a framed byte stream into 18-bit words, writes them to
// program memory and holds the CPU in reset until a good frame has loaded.
// Define PMEM_LOADER_CHECKSUM_EN to require a trailing mod-256 checksum byte.
module pmem_loader
   import loader_pkg::*;
#(
   parameter int                    ADDR_WIDTH     = 16,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
   parameter int                    TIMEOUT_CYCLES = 100000,
   parameter bit                    BOOT_LOAD      = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   input  logic                  load_req,
   output logic                  cpu_rst,
   output logic [ADDR_WIDTH-1:0] pmem_addr,
   output logic [WORD_W-1:0]     pmem_wdata,
   output logic                  pmem_wen,
   output logic                  done,
   output logic                  err
);

   loader_state_t         state_q;
   logic                  cpu_rst_q, wen_q, done_q, err_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [WORD_W-1:0]     wdata_q;
   logic [15:0]           len_q;
   logic [1:0]            bidx_q;
   logic [1:0]            b2_q;
   logic [7:0]            b1_q;
   logic [7:0]            sum_q;
   logic                  run, to_expire;

   assign run = (state_q == LEN_HI) || (state_q == LEN_LO) ||
                (state_q == WORD)   || (state_q == CHECK);

   loader_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
      .clk      (clk),
      .rst      (rst),
      .run_i    (run),
      .clr_i    (rx_valid),
      .expire_o (to_expire)
   );

`ifdef PMEM_LOADER_CHECKSUM_EN
   localparam loader_state_t LAST_ST = CHECK;
`else
   localparam loader_state_t LAST_ST = FINISH;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= BOOT_LOAD ? WAIT_MAGIC : IDLE;
         cpu_rst_q <= BOOT_LOAD;
         wen_q     <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         addr_q    <= BASE_ADDR;
         wdata_q   <= '0;
         len_q     <= '0;
         bidx_q    <= '0;
         b2_q      <= '0;
         b1_q      <= '0;
         sum_q     <= '0;
      end else begin
         wen_q <= 1'b0;
         if (wen_q)
            addr_q <= addr_q + 1'b1;

         // Abort paths never touch cpu_rst: it is already held high here.
         if (to_expire) begin
            err_q   <= 1'b1;
            state_q <= WAIT_MAGIC;
         end else begin
            case (state_q)
               IDLE: begin
                  if (load_req) begin
                     cpu_rst_q <= 1'b1;
                     state_q   <= WAIT_MAGIC;
                  end
               end
               WAIT_MAGIC: begin
                  if (rx_valid && rx_data == LOADER_MAGIC) begin
                     done_q  <= 1'b0;
                     err_q   <= 1'b0;
                     addr_q  <= BASE_ADDR;
                     sum_q   <= '0;
                     bidx_q  <= '0;
                     state_q <= LEN_HI;
                  end
               end
               LEN_HI: begin
                  if (rx_valid) begin
                     len_q[15:8] <= rx_data;
                     state_q     <= LEN_LO;
                  end
               end
               LEN_LO: begin
                  if (rx_valid) begin
                     len_q[7:0] <= rx_data;
                     state_q    <= ({len_q[15:8], rx_data} == 16'd0) ? LAST_ST : WORD;
                  end
               end
               WORD: begin
                  if (rx_valid) begin
                     sum_q <= sum_q + rx_data;
                     case (bidx_q)
                        2'd0: begin
                           if (rx_data[7:2] != 6'd0) begin
                              err_q   <= 1'b1;
                              state_q <= WAIT_MAGIC;
                           end else begin
                              b2_q   <= rx_data[1:0];
                              bidx_q <= 2'd1;
                           end
                        end
                        2'd1: begin
                           b1_q   <= rx_data;
                           bidx_q <= 2'd2;
                        end
                        default: begin
                           wdata_q <= mk_word(b2_q, b1_q, rx_data);
                           wen_q   <= 1'b1;
                           bidx_q  <= 2'd0;
                           len_q   <= len_q - 1'b1;
                           if (len_q == 16'd1)
                              state_q <= LAST_ST;
                        end
                     endcase
                  end
               end
               CHECK: begin
                  if (rx_valid) begin
                     if (rx_data == sum_q) begin
                        state_q <= FINISH;
                     end else begin
                        err_q   <= 1'b1;
                        state_q <= WAIT_MAGIC;
                     end
                  end
               end
               FINISH: begin
                  done_q    <= 1'b1;
                  cpu_rst_q <= 1'b0;
                  state_q   <= IDLE;
               end
               default: state_q <= WAIT_MAGIC;
            endcase
         end
      end
   end

   assign cpu_rst    = cpu_rst_q;
   assign pmem_addr  = addr_q;
   assign pmem_wdata = wdata_q;
   assign pmem_wen   = wen_q;
   assign done       = done_q;
   assign err        = err_q;

endmodule
